// File: rtl/full_adder_b.sv
// Registered ripple-carry adder: {c, s} = a + b + c0, one cycle of latency.
// WIDTH=1 is the classic full adder, and wider instances chain cells LSB-first.
module full_adder_b #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_d, c_q;
  logic             k;

  // Walk the cells from bit 0 upward; k carries k_i into cell i.
  always_comb begin
    k   = c0;
    s_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s_d[i] = a[i] ^ b[i] ^ k;
      k      = (a[i] & b[i]) | (a[i] & k) | (b[i] & k);
    end
    c_d = k;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign s = s_q;
  assign c = c_q;

endmodule

// File: tb/tb_full_adder_b.sv
// Directed vector bench for full_adder_b.
// It drives WIDTH=1 and WIDTH=4 instances side by side.
module tb_full_adder_b;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c0;
    logic [3:0] s;
    logic       co;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, ci1;
  logic       s1, c1;
  logic [3:0] a4, b4, s4;
  logic       ci4, c4;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t v1[8];
  vec_t v4[8];

  always #5 clk = ~clk;

  full_adder_b #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst),
    .a(a1), .b(b1), .c0(ci1),
    .s(s1), .c(c1)
  );

  full_adder_b #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst),
    .a(a4), .b(b4), .c0(ci4),
    .s(s4), .c(c4)
  );

  task automatic check(input string nm,
                       input logic [4:0] got,
                       input logic [4:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic a, input logic b, input logic ci);
    @(negedge clk);
    a1 = a; b1 = b; ci1 = ci;
  endtask

  task automatic drv4(input logic [3:0] a, input logic [3:0] b,
                      input logic ci);
    @(negedge clk);
    a4 = a; b4 = b; ci4 = ci;
  endtask

  initial begin
    // WIDTH=1 truth table, hand computed
    v1[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    v1[1] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0};
    v1[2] = '{4'h0, 4'h1, 1'b0, 4'h1, 1'b0};
    v1[3] = '{4'h0, 4'h1, 1'b1, 4'h0, 1'b1};
    v1[4] = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b0};
    v1[5] = '{4'h1, 4'h0, 1'b1, 4'h0, 1'b1};
    v1[6] = '{4'h1, 4'h1, 1'b0, 4'h0, 1'b1};
    v1[7] = '{4'h1, 4'h1, 1'b1, 4'h1, 1'b1};
    // WIDTH=4 wrap and ripple cases
    v4[0] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
    v4[1] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    v4[2] = '{4'h7, 4'h0, 1'b1, 4'h8, 1'b0};
    v4[3] = '{4'h5, 4'hA, 1'b0, 4'hF, 1'b0};
    v4[4] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1};
    v4[5] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0};
    v4[6] = '{4'h9, 4'h6, 1'b1, 4'h0, 1'b1};
    v4[7] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0};

    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    a4 = 4'h3; b4 = 4'h5; ci4 = 1'b1;

    // outputs held at zero while reset is high, clock running
    #1;
    check("rst_t1_w1", {3'b0, c1, s1}, 5'b00000);
    check("rst_t1_w4", {c4, s4}, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold_w1", {3'b0, c1, s1}, 5'b00000);
      check("rst_hold_w4", {c4, s4}, 5'b00000);
    end

    // first edge after release loads current inputs
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rel_w1", {3'b0, c1, s1}, 5'b00011);
    check("rel_w4", {c4, s4}, 5'b01001);

    // exhaustive single-bit sweep, one vector per cycle
    for (int i = 0; i < 8; i++) begin
      drv1(v1[i].a[0], v1[i].b[0], v1[i].c0);
      step();
      check($sformatf("w1_vec%0d", i), {3'b0, c1, s1},
            {3'b0, v1[i].co, v1[i].s[0]});
    end

    // back-to-back operand changes, one-cycle lag
    drv1(1'b0, 1'b0, 1'b0);
    step();
    check("b2b_0", {3'b0, c1, s1}, 5'b00000);
    drv1(1'b1, 1'b0, 1'b1);
    step();
    check("b2b_1", {3'b0, c1, s1}, 5'b00010);
    drv1(1'b0, 1'b1, 1'b0);
    step();
    check("b2b_2", {3'b0, c1, s1}, 5'b00001);

    // async reset between edges clears outputs immediately
    drv1(1'b1, 1'b1, 1'b0);
    drv4(4'hF, 4'hF, 1'b1);
    step();
    check("pre_arst_w1", {3'b0, c1, s1}, 5'b00010);
    check("pre_arst_w4", {c4, s4}, 5'b11111);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_now_w1", {3'b0, c1, s1}, 5'b00000);
    check("arst_now_w4", {c4, s4}, 5'b00000);
    step();
    check("arst_edge_w1", {3'b0, c1, s1}, 5'b00000);
    check("arst_edge_w4", {c4, s4}, 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("arst_rel_w1", {3'b0, c1, s1}, 5'b00010);
    check("arst_rel_w4", {c4, s4}, 5'b11111);

    // four-bit wrap and carry propagation table
    for (int i = 0; i < 8; i++) begin
      drv4(v4[i].a, v4[i].b, v4[i].c0);
      step();
      check($sformatf("w4_vec%0d", i), {c4, s4}, {v4[i].co, v4[i].s});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
